div_sequencer: RTL

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer_if.sv | 42 ++++
 rtl/div_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/div_sequencer_if.sv
// ============================================================================
// div_sequencer_if : host request/result and divider handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface div_sequencer_if;
   logic        en;
   logic        req;
   logic        u;
   logic [31:0] x;
   logic [31:0] y;
   logic        ready;
   logic        div_run;
   logic        div_u;
   logic [31:0] div_x;
   logic [31:0] div_y;
   logic        div_stall;
   logic [31:0] div_quot;
   logic [31:0] div_rem;
   logic        done;
   logic [31:0] quot;
   logic [31:0] rem;
   logic        err_zero;
   logic        err_neg;
   logic        err_tmo;

   // slave is the sequencer's view, master is the host/divider side
   modport slave (
      input  en, req, u, x, y, div_stall, div_quot, div_rem,
      output ready, div_run, div_u, div_x, div_y, done, quot, rem,
             err_zero, err_neg, err_tmo
   );

   modport master (
      output en, req, u, x, y, div_stall, div_quot, div_rem,
      input  ready, div_run, div_u, div_x, div_y, done, quot, rem,
             err_zero, err_neg, err_tmo
   );
endinterface

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// div_sequencer : screens operands, runs one divide on an iterative divider
// Rev 1.0
// ============================================================================
`default_nettype none

module div_sequencer #(
   parameter int TIMEOUT = 40
) (
   input  wire logic      clk,
   input  wire logic      rst,
   div_sequencer_if.slave bus
);

   localparam int c_cnt_w = $clog2(TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic                 r_div_u;
   logic [31:0]          r_div_x;
   logic [31:0]          r_div_y;
   logic [31:0]          r_quot;
   logic [31:0]          r_rem;
   logic                 r_err_zero;
   logic                 r_err_neg;
   logic                 r_err_tmo;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_div_u    <= 1'b0;
         r_div_x    <= '0;
         r_div_y    <= '0;
         r_quot     <= '0;
         r_rem      <= '0;
         r_err_zero <= 1'b0;
         r_err_neg  <= 1'b0;
         r_err_tmo  <= 1'b0;
      end else if (bus.en) begin
         case (r_state)
            IDLE: begin
               if (bus.req) begin
                  r_div_x    <= bus.x;
                  r_div_y    <= bus.y;
                  r_div_u    <= bus.u;
                  r_err_zero <= 1'b0;
                  r_err_neg  <= 1'b0;
                  r_err_tmo  <= 1'b0;
                  // Rejected divisors never reach the divider: dividend is returned as remainder
                  if (bus.y == 32'd0) begin
                     r_err_zero <= 1'b1;
                     r_quot     <= '0;
                     r_rem      <= bus.x;
                     r_state    <= DONE;
                  end else if (bus.y[31]) begin
                     r_err_neg  <= 1'b1;
                     r_quot     <= '0;
                     r_rem      <= bus.x;
                     r_state    <= DONE;
                  end else begin
                     r_cnt      <= '0;
                     r_state    <= RUN;
                  end
               end
            end
            RUN: begin
               // A result arriving on the last allowed cycle takes priority over the timeout
               if (!bus.div_stall) begin
                  r_quot  <= bus.div_quot;
                  r_rem   <= bus.div_rem;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == c_tmo_last) begin
                     r_err_tmo <= 1'b1;
                     r_quot    <= '0;
                     r_rem     <= '0;
                     r_state   <= DONE;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready    = (r_state == IDLE);
   assign bus.div_run  = (r_state == RUN);
   assign bus.done     = (r_state == DONE);
   assign bus.div_u    = r_div_u;
   assign bus.div_x    = r_div_x;
   assign bus.div_y    = r_div_y;
   assign bus.quot     = r_quot;
   assign bus.rem      = r_rem;
   assign bus.err_zero = r_err_zero;
   assign bus.err_neg  = r_err_neg;
   assign bus.err_tmo  = r_err_tmo;

endmodule

`default_nettype wire
